// File: rtl/udp_tx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : udp_tx_pkg
//  Description : Shared types and constants for the UDP transmit packetizer.
//                The transmit FSM state encoding lives here.
//                UDP_MIN_PAYLOAD is the padded length used when the
//                UDP_TX_MIN_PAD_EN build option is enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_tx_pkg;

  localparam int UDP_MIN_PAYLOAD = 18;
  localparam int LEN_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARP_REQ  = 3'd1,
    ST_ARP_WAIT = 3'd2,
    ST_REQ      = 3'd3,
    ST_WRITE    = 3'd4,
    ST_WAIT_END = 3'd5
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO. The head entry is visible on
//                o_rd_data whenever o_empty is low. i_rd_en consumes it.
//                DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Read/write pointer update; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/udp_tx_packetizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : udp_tx_packetizer
//  Description : Slices an application byte stream into UDP payloads of at
//                most PKT_LEN bytes. It resolves the destination MAC via ARP
//                with periodic retry, then feeds the MAC through its
//                request / grant / write / end handshake.
//                Build option UDP_TX_MIN_PAD_EN pads short payloads with
//                zero bytes up to UDP_MIN_PAYLOAD.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_packetizer
  import udp_tx_pkg::*;
#(
  parameter int PKT_LEN          = 1024,
  parameter int FIFO_DEPTH       = 2048,
  parameter int LEN_DEPTH        = 4,
  parameter int ARP_RETRY_CYCLES = 1250000,
  parameter int TX_TIMEOUT       = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             arp_found,
  input  logic             mac_not_exist,
  output logic             arp_request_req,
  output logic             udp_tx_req,
  output logic [LEN_W-1:0] udp_send_data_length,
  input  logic             udp_ram_data_req,
  input  logic             almost_full,
  output logic [7:0]       ram_wr_data,
  output logic             ram_wr_en,
  input  logic             udp_tx_end,
  output logic             busy,
  output logic             pkt_sent,
  output logic             tx_timeout
);

  logic             w_data_full, w_data_empty, w_len_full, w_len_empty;
  logic [7:0]       w_data_head;
  logic [10:0]      w_len_head;
  logic [10:0]      r_open_cnt, w_open_next;
  logic             w_accept, w_close;
  tx_state_t        r_state, w_state_next;
  logic [LEN_W-1:0] w_real_len, w_tx_len;
  logic [LEN_W-1:0] r_len, r_remain, r_pad;
  logic [31:0]      r_tmr;
  logic             w_slot, w_data_pop, w_len_pop, w_enter_req;
  logic             r_wr_en, r_pkt_sent, r_tx_timeout;
  logic [7:0]       r_wr_data;

  assign s_ready     = !rst && !w_data_full && !w_len_full;
  assign w_accept    = s_valid && s_ready;
  assign w_open_next = r_open_cnt + 11'd1;
  // A packet closes once, whether s_last, the size limit, or both end it.
  assign w_close     = w_accept && (s_last || (w_open_next == 11'(PKT_LEN)));

  // Byte count of the packet currently being assembled.
  always_ff @(posedge clk) begin
    if (rst)           r_open_cnt <= '0;
    else if (w_close)  r_open_cnt <= '0;
    else if (w_accept) r_open_cnt <= w_open_next;
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_accept),
    .i_wr_data (s_data),
    .i_rd_en   (w_data_pop),
    .o_rd_data (w_data_head),
    .o_full    (w_data_full),
    .o_empty   (w_data_empty)
  );

  sync_fifo #(.WIDTH(11), .DEPTH(LEN_DEPTH)) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_close),
    .i_wr_data (w_open_next),
    .i_rd_en   (w_len_pop),
    .o_rd_data (w_len_head),
    .o_full    (w_len_full),
    .o_empty   (w_len_empty)
  );

  assign w_real_len = {5'd0, w_len_head};
`ifdef UDP_TX_MIN_PAD_EN
  assign w_tx_len = (w_real_len < LEN_W'(UDP_MIN_PAYLOAD)) ? LEN_W'(UDP_MIN_PAYLOAD) : w_real_len;
`else
  assign w_tx_len = w_real_len;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and per-state strobes; write slots only while the MAC has room.
  always_comb begin
    w_state_next    = r_state;
    arp_request_req = 1'b0;
    udp_tx_req      = 1'b0;
    w_slot          = 1'b0;
    w_data_pop      = 1'b0;
    w_len_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_len_empty) begin
          w_state_next = (arp_found && !mac_not_exist) ? ST_REQ : ST_ARP_REQ;
        end
      end
      ST_ARP_REQ: begin
        arp_request_req = 1'b1;
        w_state_next    = ST_ARP_WAIT;
      end
      ST_ARP_WAIT: begin
        if (arp_found)        w_state_next = ST_REQ;
        else if (r_tmr == '0) w_state_next = ST_ARP_REQ;
      end
      ST_REQ: begin
        udp_tx_req = 1'b1;
        if (udp_ram_data_req) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (r_remain == '0) begin
          w_len_pop    = 1'b1;
          w_state_next = ST_WAIT_END;
        end else if (!almost_full) begin
          w_slot     = 1'b1;
          // Real bytes come first; the trailing r_pad slots write zeros.
          w_data_pop = (r_remain > r_pad);
        end
      end
      ST_WAIT_END: begin
        // udp_tx_end wins over a simultaneous timeout expiry.
        if (udp_tx_end || (r_tmr == '0)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_enter_req = (r_state != ST_REQ) && (w_state_next == ST_REQ);

  // Registered datapath: length capture, write countdown, timers and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len        <= '0;
      r_remain     <= '0;
      r_pad        <= '0;
      r_tmr        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_pkt_sent   <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_wr_en      <= w_slot;
      if (w_slot) r_wr_data <= w_data_pop ? w_data_head : 8'h00;
      r_pkt_sent   <= (r_state == ST_WAIT_END) && udp_tx_end;
      r_tx_timeout <= (r_state == ST_WAIT_END) && !udp_tx_end && (r_tmr == '0);
      if (w_enter_req) begin
        r_len    <= w_tx_len;
        r_remain <= w_tx_len;
        r_pad    <= w_tx_len - w_real_len;
      end else if (w_slot) begin
        r_remain <= r_remain - 16'd1;
      end
      if (r_state == ST_ARP_REQ)
        r_tmr <= 32'(ARP_RETRY_CYCLES - 1);
      else if ((r_state == ST_WRITE) && (w_state_next == ST_WAIT_END))
        r_tmr <= 32'(TX_TIMEOUT - 1);
      else if (r_tmr != '0)
        r_tmr <= r_tmr - 32'd1;
    end
  end

  assign udp_send_data_length = r_len;
  assign ram_wr_en            = r_wr_en;
  assign ram_wr_data          = r_wr_data;
  assign pkt_sent             = r_pkt_sent;
  assign tx_timeout           = r_tx_timeout;
  assign busy                 = (r_state != ST_IDLE) || !w_len_empty || !w_data_empty;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_packetizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_udp_tx_packetizer
//  Description : Self-checking bench for udp_tx_packetizer. A MAC responder
//                grants requests, records writes and pulses udp_tx_end.
//                Expected payloads and lengths come from a queue model of
//                the packet-slicing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_packetizer;

  localparam int PKT_LEN = 1024;
  localparam int ARP_N   = 40;
  localparam int TO_N    = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic        arp_found = 1'b1, mac_not_exist = 1'b0, arp_request_req;
  logic        udp_tx_req, udp_ram_data_req = 1'b0, almost_full = 1'b0;
  logic [15:0] udp_send_data_length;
  logic [7:0]  ram_wr_data;
  logic        ram_wr_en, udp_tx_end = 1'b0, busy, pkt_sent, tx_timeout;

  int total = 0, bad = 0;

  // Observations and model state.
  logic [7:0]  q_wr[$], q_expwr[$], q_cur[$];
  logic [15:0] q_len[$], q_explen[$];
  int          q_arp[$];
  int cyc = 0, n_sent = 0, n_to = 0, n_afviol = 0, n_arpwide = 0;
  int last_wr_cyc = 0, to_cyc = 0, wcount = 0, delay = 0, afc = 0, af_mode = 0;
  bit armed = 0, req_prev = 0, arp_prev = 0, end_en = 1;

  udp_tx_packetizer #(
    .PKT_LEN(PKT_LEN), .FIFO_DEPTH(2048), .LEN_DEPTH(4),
    .ARP_RETRY_CYCLES(ARP_N), .TX_TIMEOUT(TO_N)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .arp_found(arp_found), .mac_not_exist(mac_not_exist),
    .arp_request_req(arp_request_req), .udp_tx_req(udp_tx_req),
    .udp_send_data_length(udp_send_data_length), .udp_ram_data_req(udp_ram_data_req),
    .almost_full(almost_full), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .udp_tx_end(udp_tx_end), .busy(busy), .pkt_sent(pkt_sent), .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Reference model: a packet closes on s_last or when it holds PKT_LEN bytes.
  function automatic void model_byte(input logic [7:0] d, input bit last);
    int rep;
    q_cur.push_back(d);
    if (last || q_cur.size() == PKT_LEN) begin
      rep = q_cur.size();
`ifdef UDP_TX_MIN_PAD_EN
      if (rep < 18) rep = 18;
`endif
      q_explen.push_back(16'(rep));
      foreach (q_cur[i]) q_expwr.push_back(q_cur[i]);
      for (int i = q_cur.size(); i < rep; i++) q_expwr.push_back(8'h00);
      q_cur.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit last);
    int g = 0;
    s_data = d; s_last = last; s_valid = 1'b1;
    while (!s_ready && g < 5000) begin tick(); g++; end
    if (g >= 5000) check("ingress_stall", {63'd0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit with_last, input bit use_model);
    logic [7:0] d;
    bit l;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      l = with_last && (i == n - 1);
      if (use_model) model_byte(d, l);
      send_byte(d, l);
      if ($urandom_range(3) == 0) tick();
    end
  endtask

  task automatic wait_sent(input int target, input string tag);
    for (int i = 0; i < 30000 && n_sent < target; i++) tick();
    check(tag, n_sent, target);
  endtask

  // MAC responder: observes DUT outputs and drives the MAC-side inputs.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (ram_wr_en) begin
        if (almost_full) n_afviol++;   // a write decided while almost_full was high
        q_wr.push_back(ram_wr_data);
        wcount++;
        last_wr_cyc = cyc;
      end
      if (udp_tx_req && !req_prev) begin
        q_len.push_back(udp_send_data_length);
        armed = 1; wcount = 0;
      end
      req_prev = udp_tx_req;
      if (pkt_sent) n_sent++;
      if (tx_timeout) begin n_to++; to_cyc = cyc; end
      if (arp_request_req) begin
        q_arp.push_back(cyc);
        if (arp_prev) n_arpwide++;
      end
      arp_prev = arp_request_req;
      udp_ram_data_req = udp_tx_req;
      udp_tx_end = 1'b0;
      if (delay != 0) begin
        delay--;
        if (delay == 0) udp_tx_end = 1'b1;
      end
      if (armed && wcount == int'(udp_send_data_length)) begin
        armed = 0;
        if (end_en) delay = 3;
      end
      if (rst) begin armed = 0; delay = 0; req_prev = 0; udp_tx_end = 1'b0; end
      afc++;
      almost_full = (af_mode == 1) ? ((afc % 6) >= 3) : 1'b0;
    end
  end

  initial begin
    int a0, l0, s0, t0, gap, mism, ws, ew, el;
    repeat (3) tick();
    check("reset_outputs",
          {33'd0, s_ready, arp_request_req, udp_tx_req, udp_send_data_length,
           ram_wr_data, ram_wr_en, busy, pkt_sent, tx_timeout}, 64'd0);
    rst = 1'b0;
    tick();

    // Long stream: 3000 bytes, only the last one carries s_last.
    send_pkt(3000, 1, 1);
    wait_sent(3, "stream_pkt_sent");

    // ARP unresolved: retry pulses, then resolution.
    arp_found = 1'b0; mac_not_exist = 1'b1;
    a0 = q_arp.size(); l0 = q_len.size(); s0 = n_sent;
    send_pkt(10, 1, 1);
    for (int i = 0; i < 1000 && q_arp.size() < a0 + 2; i++) tick();
    check("arp_two_pulses", {63'd0, q_arp.size() >= a0 + 2}, 64'd1);
    if (q_arp.size() >= a0 + 2) begin
      gap = q_arp[a0 + 1] - q_arp[a0];
      check("arp_retry_gap", {63'd0, (gap >= ARP_N) && (gap <= ARP_N + 1)}, 64'd1);
    end
    check("no_req_before_arp", q_len.size(), l0);
    arp_found = 1'b1; mac_not_exist = 1'b0;
    wait_sent(s0 + 1, "arp_pkt_sent");

    // Back-pressure: almost_full toggling, packet closed by both rules at once.
    af_mode = 1;
    s0 = n_sent;
    send_pkt(PKT_LEN, 1, 1);
    wait_sent(s0 + 1, "af_pkt_sent");
    check("af_write_violations", n_afviol, 0);
    af_mode = 0;

    // Missing udp_tx_end: timeout on the first packet, second goes normally.
    end_en = 0;
    s0 = n_sent; t0 = n_to;
    send_pkt(7, 1, 1);
    send_pkt(30, 1, 1);
    for (int i = 0; i < 3000 && n_to < t0 + 1; i++) tick();
    check("tx_timeout_pulse", n_to - t0, 1);
    gap = to_cyc - last_wr_cyc;
    check("tx_timeout_delay", {63'd0, (gap >= TO_N) && (gap <= TO_N + 2)}, 64'd1);
    end_en = 1;
    wait_sent(s0 + 1, "after_timeout_sent");

    // Shortest packets: 1 and 5 bytes (padded to 18 when padding is built in).
    s0 = n_sent;
    send_pkt(1, 1, 1);
    send_pkt(5, 1, 1);
    wait_sent(s0 + 2, "short_pkt_sent");

    // Whole-run comparison of lengths and payload bytes against the model.
    check("req_count", q_len.size(), q_explen.size());
    for (int i = 0; i < q_explen.size() && i < q_len.size(); i++)
      check($sformatf("len[%0d]", i), q_len[i], q_explen[i]);
    check("wr_count", q_wr.size(), q_expwr.size());
    mism = 0;
    for (int i = 0; i < q_expwr.size() && i < q_wr.size(); i++)
      if (q_wr[i] !== q_expwr[i]) mism++;
    check("wr_byte_mismatches", mism, 0);
    check("arp_pulse_width", n_arpwide, 0);
    check("tx_timeout_total", n_to, 1);

    // Reset in the middle of a 500-byte write.
    ew = q_expwr.size(); el = q_explen.size();
    af_mode = 1;
    ws = q_wr.size();
    send_pkt(500, 1, 0);
    for (int i = 0; i < 5000 && q_wr.size() < ws + 100; i++) tick();
    check("mid_write_progress", {63'd0, q_wr.size() >= ws + 100}, 64'd1);
    rst = 1'b1;
    tick();
    check("mid_reset_outputs",
          {33'd0, s_ready, arp_request_req, udp_tx_req, udp_send_data_length,
           ram_wr_data, ram_wr_en, busy, pkt_sent, tx_timeout}, 64'd0);
    ws = q_wr.size();
    tick();
    rst = 1'b0; af_mode = 0;
    repeat (10) tick();
    check("no_writes_after_reset", q_wr.size(), ws);
    check("busy_after_reset", {63'd0, busy}, 64'd0);
    check("ready_after_reset", {63'd0, s_ready}, 64'd1);

    // A fresh packet after reset must carry only its own bytes.
    s0 = n_sent;
    send_pkt(3, 1, 1);
    wait_sent(s0 + 1, "post_reset_sent");
    check("post_reset_wr_count", q_wr.size() - ws, q_expwr.size() - ew);
    mism = 0;
    for (int i = 0; i < q_expwr.size() - ew && ws + i < q_wr.size(); i++)
      if (q_wr[ws + i] !== q_expwr[ew + i]) mism++;
    check("post_reset_bytes", mism, 0);
    check("post_reset_len", q_len[q_len.size() - 1], q_explen[el]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_tx_packetizer.md
Name: udp_tx_packetizer

Overview:
- Upstream feeder for the UDP transmit path. Accepts an application byte stream and slices it into UDP payloads of at most PKT_LEN bytes.
- Resolves the destination MAC via ARP request/retry, then drives the MAC's UDP handshake: udp_tx_req / udp_ram_data_req / ram_wr_en / udp_tx_end, with almost_full back-pressure.
- Single clock domain, on the gmii_tx_clk-side clock.

Parameters:
- PKT_LEN, 1024: maximum payload bytes per packet (1..1472).
- FIFO_DEPTH, 2048: data FIFO depth in bytes. Power of 2, at least PKT_LEN.
- LEN_DEPTH, 4: depth of the closed-packet length queue. Power of 2.
- ARP_RETRY_CYCLES, 1250000: cycles between ARP request retries.
- TX_TIMEOUT, 65535: maximum cycles to wait for udp_tx_end.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_data  in  8  application byte
- s_valid  in  1  byte valid
- s_last  in  1  closes the current packet after this byte
- s_ready  out  1  byte accepted when s_valid and s_ready are both high
- arp_found  in  1  destination MAC resolved (level)
- mac_not_exist  in  1  destination MAC absent from cache (level)
- arp_request_req  out  1  one-cycle ARP request pulse
- udp_tx_req  out  1  send request, held until grant
- udp_send_data_length  out  16  payload length of the current packet
- udp_ram_data_req  in  1  grant: MAC ready to accept payload writes
- almost_full  in  1  MAC payload buffer back-pressure
- ram_wr_data  out  8  payload byte
- ram_wr_en  out  1  payload byte strobe
- udp_tx_end  in  1  MAC transmission complete pulse
- busy  out  1  FSM not in IDLE, or any packet pending
- pkt_sent  out  1  one-cycle pulse per completed packet
- tx_timeout  out  1  one-cycle pulse when udp_tx_end is not seen within TX_TIMEOUT

Behaviour:
- Reset. All outputs 0. Both FIFOs are emptied, the open-packet counter is cleared, FSM goes to IDLE. This applies mid-packet as well: any partially written payload is abandoned, and no further ram_wr_en is issued after the reset cycle.
- Ingress
  - s_ready = !data_full && !len_full.
  - Each accepted byte is pushed to the data FIFO and increments open_cnt (11 bits).
  - The packet closes when s_last is accepted, or when open_cnt reaches PKT_LEN. If both happen on the same byte, it closes once.
  - On close, open_cnt is pushed to the length FIFO and open_cnt resets to 0.
  - Packet length is always at least 1.
- FSM states: IDLE, ARP_REQ, ARP_WAIT, REQ, WRITE, WAIT_END.
  - IDLE: when the length FIFO is non-empty, go to REQ if arp_found=1 and mac_not_exist=0; otherwise go to ARP_REQ.
  - ARP_REQ: arp_request_req=1 for exactly 1 cycle; load the retry counter with ARP_RETRY_CYCLES-1; go to ARP_WAIT.
  - ARP_WAIT: arp_found=1 goes to REQ. Counter reaching 0 goes back to ARP_REQ. There is no retry limit.
  - REQ: udp_send_data_length is registered from the length-FIFO head on REQ entry and is stable until WAIT_END exits. udp_tx_req=1 every cycle in REQ. When udp_ram_data_req=1 is sampled, go to WRITE; udp_tx_req=0 from that next cycle.
  - WRITE:
    - Each cycle with almost_full=0 and remaining>0: pop one data-FIFO byte (show-ahead FIFO) and decrement remaining.
    - ram_wr_data/ram_wr_en are registered, so they appear 1 cycle after the pop decision. The MAC threshold must absorb 1 in-flight byte.
    - With almost_full=1, no pop occurs.
    - After the final write, pop the length FIFO and go to WAIT_END.
  - WAIT_END: udp_tx_end=1 goes to IDLE with pkt_sent=1. If the TX_TIMEOUT counter expires first, go to IDLE with tx_timeout=1 and drop the packet (the length entry is already popped).
- Ordering. Packets go out strictly FIFO. Ingress continues in every state.
- Simultaneous events. udp_tx_end arriving in the same cycle as the timeout expiry counts as success.

Optional Feature:
- Macro UDP_TX_MIN_PAD_EN.
- Defined: packets shorter than 18 bytes report udp_send_data_length=18. After the real bytes, the block writes zero bytes (no FIFO pop) until 18 bytes total, still honouring almost_full.
- Undefined: length is exact and no padding is written.

Decomposition:
- Package udp_tx_pkg holds:
  - FSM state encoding constants.
  - UDP_MIN_PAYLOAD=18.
  - Length width 16.
- Sub-module sync_fifo: single-clock, show-ahead, parameter WIDTH/DEPTH, full/empty flags.
  - Instantiated twice: 8-bit data FIFO and 11-bit length FIFO.

Test Plan:
- arp_found=1; stream 3000 bytes with no s_last, PKT_LEN=1024 -> three udp_tx_req with lengths 1024, 1024, 952 (last closed by s_last on byte 3000); ram_wr_data matches input order; pkt_sent x3.
- arp_found=0: one 10-byte packet -> arp_request_req pulse, second pulse after ARP_RETRY_CYCLES; set arp_found=1 -> REQ, length 10 written.
- almost_full toggled every 3 cycles during WRITE -> no ram_wr_en more than 1 cycle after almost_full rises; total written bytes equal length; no byte lost or duplicated.
- udp_tx_end withheld -> tx_timeout pulses after TX_TIMEOUT cycles; next queued packet is sent normally.
- rst asserted mid-WRITE with 500 bytes queued -> all outputs 0 the next cycle, FIFOs empty, busy=0.
- UDP_TX_MIN_PAD_EN defined: 5-byte packet -> length 18; 5 data bytes then 13 zero bytes. Undefined: length 5, 5 writes.
